// File: rtl/model_arithmetic_pkg.sv
// Shared definitions for the model arithmetic blocks: feeder FSM states and
// width-specific zero/one constants.
package model_arithmetic_pkg;

    localparam int FEEDER_DATA_SIZE    = 64;
    localparam int FEEDER_CONTROL_SIZE = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KICK  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } feeder_state_t;

    localparam logic [FEEDER_CONTROL_SIZE-1:0] ZERO_CONTROL = '0;
    localparam logic [FEEDER_CONTROL_SIZE-1:0] ONE_CONTROL  = FEEDER_CONTROL_SIZE'(1);
    localparam logic [FEEDER_DATA_SIZE-1:0]    ZERO_DATA    = '0;
    localparam logic [FEEDER_DATA_SIZE-1:0]    ONE_DATA     = FEEDER_DATA_SIZE'(1);

endpackage

// File: rtl/model_vector_integer_buffer.sv
// Operand buffer: DEPTH x DATA_SIZE register array filled in order, with an
// element count, a full flag and a combinational read port.
module model_vector_integer_buffer #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    WRITE_ENABLE,
    input  logic [DATA_SIZE-1:0]    WRITE_DATA,
    input  logic                    CLEAR,
    input  logic [CONTROL_SIZE-1:0] READ_INDEX,
    output logic [DATA_SIZE-1:0]    READ_DATA,
    output logic [CONTROL_SIZE:0]   COUNT,
    output logic                    FULL
);

    localparam int DEPTH = 2 ** CONTROL_SIZE;

    logic [DATA_SIZE-1:0] mem [DEPTH];

    assign FULL      = (COUNT == (CONTROL_SIZE + 1)'(DEPTH));
    assign READ_DATA = mem[READ_INDEX];

    // A write arriving while full is dropped; the count saturates at DEPTH.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            COUNT <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (CLEAR) begin
            COUNT <= '0;
        end else if (WRITE_ENABLE && !FULL) begin
            mem[COUNT[CONTROL_SIZE-1:0]] <= WRITE_DATA;
            COUNT                        <= COUNT + (CONTROL_SIZE + 1)'(1);
        end
    end

endmodule

// File: rtl/model_vector_integer_divider_feeder.sv
// Operand feeder for the vector integer divider: buffers A/B elements and
// hands them to the divider one pair per quotient. Optional zero-divisor
// substitution is enabled by defining MODEL_VECTOR_DIVIDER_FEEDER_ZERO_CHECK_EN.
module model_vector_integer_divider_feeder
    import model_arithmetic_pkg::*;
#(
    parameter int DATA_SIZE    = FEEDER_DATA_SIZE,
    parameter int CONTROL_SIZE = FEEDER_CONTROL_SIZE
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    LOAD_A_ENABLE,
    input  logic [DATA_SIZE-1:0]    LOAD_A_DATA,
    input  logic                    LOAD_B_ENABLE,
    input  logic [DATA_SIZE-1:0]    LOAD_B_DATA,
    input  logic                    START,
    input  logic [DATA_SIZE-1:0]    SIZE_IN,
    output logic                    READY,
    output logic                    SIZE_ERROR,
    output logic                    DIV_START,
    output logic                    DIV_DATA_A_ENABLE,
    output logic                    DIV_DATA_B_ENABLE,
    output logic [DATA_SIZE-1:0]    DIV_DATA_A_OUT,
    output logic [DATA_SIZE-1:0]    DIV_DATA_B_OUT,
    input  logic                    DIV_DATA_OUT_ENABLE_IN,
    output logic                    ZERO_DIVISOR_ERROR,
    output feeder_state_t           STATE_DEBUG,
    output logic [CONTROL_SIZE:0]   COUNT_A_DEBUG,
    output logic [CONTROL_SIZE:0]   COUNT_B_DEBUG
);

    // Handshake: DIV_START pulses once per accepted run; each element pair is
    // valid only in the cycle DIV_DATA_A/B_ENABLE are high, and the next pair
    // is issued only after DIV_DATA_OUT_ENABLE_IN is sampled high in WAIT.

    localparam logic [CONTROL_SIZE-1:0] IDX_ZERO  = CONTROL_SIZE'(ZERO_CONTROL);
    localparam logic [CONTROL_SIZE-1:0] IDX_ONE   = CONTROL_SIZE'(ONE_CONTROL);
    localparam logic [DATA_SIZE-1:0]    DATA_ZERO = DATA_SIZE'(ZERO_DATA);

    feeder_state_t           state;
    logic [CONTROL_SIZE-1:0] index;
    logic [CONTROL_SIZE-1:0] last_index;
    logic [CONTROL_SIZE-1:0] rd_index;
    logic [DATA_SIZE-1:0]    a_rd;
    logic [DATA_SIZE-1:0]    b_rd;
    logic [DATA_SIZE-1:0]    issue_b;
    logic [CONTROL_SIZE:0]   count_a;
    logic [CONTROL_SIZE:0]   count_b;
    logic                    full_a;
    logic                    full_b;
    logic                    write_a;
    logic                    write_b;
    logic                    size_ok;
    logic                    more_left;
    logic                    issue_now;

    assign write_a = LOAD_A_ENABLE && (state == IDLE) && !full_a;
    assign write_b = LOAD_B_ENABLE && (state == IDLE) && !full_b;

    // Counts here are the pre-write values, so a load in the START cycle
    // never widens the acceptable size.
    assign size_ok = (SIZE_IN != DATA_ZERO)
                  && (SIZE_IN <= DATA_SIZE'(count_a))
                  && (SIZE_IN <= DATA_SIZE'(count_b));

    assign more_left = (index != last_index);
    assign issue_now = (state == KICK)
                    || ((state == WAIT) && DIV_DATA_OUT_ENABLE_IN && more_left);
    assign rd_index  = (state == WAIT) ? index + IDX_ONE : index;

`ifdef MODEL_VECTOR_DIVIDER_FEEDER_ZERO_CHECK_EN
    localparam logic [DATA_SIZE-1:0] DATA_ONE = DATA_SIZE'(ONE_DATA);
    assign issue_b = (b_rd == DATA_ZERO) ? DATA_ONE : b_rd;
`else
    assign issue_b = b_rd;
    assign ZERO_DIVISOR_ERROR = 1'b0;
`endif

    model_vector_integer_buffer #(
        .DATA_SIZE    (DATA_SIZE),
        .CONTROL_SIZE (CONTROL_SIZE)
    ) u_buffer_a (
        .CLK          (CLK),
        .RST          (RST),
        .WRITE_ENABLE (write_a),
        .WRITE_DATA   (LOAD_A_DATA),
        .CLEAR        (state == DONE),
        .READ_INDEX   (rd_index),
        .READ_DATA    (a_rd),
        .COUNT        (count_a),
        .FULL         (full_a)
    );

    model_vector_integer_buffer #(
        .DATA_SIZE    (DATA_SIZE),
        .CONTROL_SIZE (CONTROL_SIZE)
    ) u_buffer_b (
        .CLK          (CLK),
        .RST          (RST),
        .WRITE_ENABLE (write_b),
        .WRITE_DATA   (LOAD_B_DATA),
        .CLEAR        (state == DONE),
        .READ_INDEX   (rd_index),
        .READ_DATA    (b_rd),
        .COUNT        (count_b),
        .FULL         (full_b)
    );

    // Outputs are registered on entry to the state they belong to, so
    // DIV_START is high while in KICK and the enables while in ISSUE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state             <= IDLE;
            index             <= IDX_ZERO;
            last_index        <= IDX_ZERO;
            READY             <= 1'b0;
            SIZE_ERROR        <= 1'b0;
            DIV_START         <= 1'b0;
            DIV_DATA_A_ENABLE <= 1'b0;
            DIV_DATA_B_ENABLE <= 1'b0;
            DIV_DATA_A_OUT    <= DATA_ZERO;
            DIV_DATA_B_OUT    <= DATA_ZERO;
`ifdef MODEL_VECTOR_DIVIDER_FEEDER_ZERO_CHECK_EN
            ZERO_DIVISOR_ERROR <= 1'b0;
`endif
        end else begin
            READY             <= 1'b0;
            SIZE_ERROR        <= 1'b0;
            DIV_START         <= 1'b0;
            DIV_DATA_A_ENABLE <= 1'b0;
            DIV_DATA_B_ENABLE <= 1'b0;

            if (issue_now) begin
                DIV_DATA_A_ENABLE <= 1'b1;
                DIV_DATA_B_ENABLE <= 1'b1;
                DIV_DATA_A_OUT    <= a_rd;
                DIV_DATA_B_OUT    <= issue_b;
                index             <= rd_index;
`ifdef MODEL_VECTOR_DIVIDER_FEEDER_ZERO_CHECK_EN
                if (b_rd == DATA_ZERO) begin
                    ZERO_DIVISOR_ERROR <= 1'b1;
                end
`endif
            end

            case (state)
                IDLE: begin
                    if (START) begin
                        if (size_ok) begin
                            last_index <= SIZE_IN[CONTROL_SIZE-1:0] - IDX_ONE;
                            index      <= IDX_ZERO;
                            DIV_START  <= 1'b1;
                            state      <= KICK;
`ifdef MODEL_VECTOR_DIVIDER_FEEDER_ZERO_CHECK_EN
                            ZERO_DIVISOR_ERROR <= 1'b0;
`endif
                        end else begin
                            SIZE_ERROR <= 1'b1;
                        end
                    end
                end
                KICK:  state <= ISSUE;
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (DIV_DATA_OUT_ENABLE_IN) begin
                        if (more_left) begin
                            state <= ISSUE;
                        end else begin
                            READY <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign STATE_DEBUG   = state;
    assign COUNT_A_DEBUG = count_a;
    assign COUNT_B_DEBUG = count_b;

endmodule
